// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: execution-rate controller for the single-cycle RISC-V core.
//   Debounces the STEP button and RUN switch and issues a one-cycle cpu_en
//   strobe per accepted press (IDLE) or once every RUN_DIV cycles (RUN); halt
//   from the core parks the FSM in HALTED until halt=0 and run is released.
// Ports:
//   clk, rst             board clock; synchronous active-high reset
//   btn_step, sw_run     raw asynchronous button / switch inputs
//   halt                 synchronous level halt request from the core
//   cpu_en               registered single-cycle core advance strobe
//   running, halted      registered FSM state flags (never both high)
//   step_count           count of issued strobes (CNT_W bits, wraps)
// Build option: define CPU_STEP_COUNT_EN to implement the step_count counter;
//   otherwise step_count is tied to zero and no counter flops are built.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 10,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Bit 0 = step button, bit 1 = run switch.
  logic [1:0]           raw;
  logic [1:0]           sync1;
  logic [1:0]           sync2;
  logic [1:0]           acc;
  logic [1:0][DB_W-1:0] db_cnt;

  logic btn_acc;
  logic run_acc;
  logic step_prev;
  logic step_req;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             tick;
  logic             tick_nxt;
  logic             cpu_en_nxt;
  logic             running_nxt;
  logic             halted_nxt;

  assign raw = {sw_run, btn_step};

  // Two-flop synchronizers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debouncers: a new level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles that differ from the currently accepted level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        db_cnt[i] <= '0;
        acc[i]    <= 1'b0;
      end else if (sync2[i] == acc[i]) begin
        db_cnt[i] <= '0;
      end else if (db_cnt[i] == DB_LAST) begin
        acc[i]    <= sync2[i];
        db_cnt[i] <= '0;
      end else begin
        db_cnt[i] <= db_cnt[i] + DB_W'(1);
      end
    end
  end

  assign btn_acc = acc[0];
  assign run_acc = acc[1];

  // Registered rising-edge detect on the accepted button level; holding the
  // button yields one request, a release is needed before the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev <= 1'b0;
      step_req  <= 1'b0;
    end else begin
      step_prev <= btn_acc;
      step_req  <= btn_acc & ~step_prev;
    end
  end

  // FSM state register, with the registered outputs and divider that change
  // on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div     <= '0;
      tick    <= 1'b0;
      cpu_en  <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      tick    <= tick_nxt;
      cpu_en  <= cpu_en_nxt;
      running <= running_nxt;
      halted  <= halted_nxt;
    end
  end

  // Next-state logic; halt overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run_acc) state_nxt = S_RUN;
      S_RUN:    if (!run_acc) state_nxt = S_IDLE;
      S_HALTED: if (!halt && !run_acc) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (halt) state_nxt = S_HALTED;
  end

  // Output logic. The divider only advances while staying in RUN, so
  // entering RUN always starts it from zero. tick marks the terminal count
  // and is turned into cpu_en one cycle later, unless RUN is left or halt
  // arrives in that cycle.
  always_comb begin
    cpu_en_nxt  = 1'b0;
    div_nxt     = '0;
    tick_nxt    = 1'b0;
    running_nxt = (state_nxt == S_RUN);
    halted_nxt  = (state_nxt == S_HALTED);
    case (state)
      S_IDLE: cpu_en_nxt = step_req;
      S_RUN: begin
        if (state_nxt == S_RUN) begin
          cpu_en_nxt = tick;
          tick_nxt   = (div == DIV_LAST);
          div_nxt    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
      end
      default: cpu_en_nxt = 1'b0;
    endcase
    if (halt) cpu_en_nxt = 1'b0;
  end

`ifdef CPU_STEP_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cpu_en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign step_count = cnt;
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed stimulus with a strobe scoreboard.
module tb_cpu_step_ctrl;

`ifdef CPU_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b0;
  logic       sw_run = 1'b0;
  logic       halt = 1'b0;
  logic       cpu_en;
  logic       running;
  logic       halted;
  logic [3:0] step_count;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (10),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .sw_run    (sw_run),
    .halt      (halt),
    .cpu_en    (cpu_en),
    .running   (running),
    .halted    (halted),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; inputs driven at a negedge are first
  // sampled by edge edge_cnt+1.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int e;
    int c;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic int exp_cnt();
    return CNT_EN ? m_cnt : 0;
  endfunction

  task automatic push_strobe(input int e);
    sb.push_back('{e, exp_cnt()});
    m_cnt = (m_cnt + 1) % 16;
  endtask

  // Scoreboard monitor: every cpu_en pulse must match the head entry.
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].e < edge_cnt) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_strobe: got none, expected cpu_en at edge %0d (now %0d)",
               sb[0].e, edge_cnt);
      x = sb.pop_front();
    end
    if (cpu_en === 1'b1) begin
      if (sb.size() == 0 || sb[0].e != edge_cnt) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: got cpu_en=1 at edge %0d, expected 0", edge_cnt);
      end else begin
        x = sb.pop_front();
        check("strobe_step_count", int'(step_count), x.c);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  task automatic press(input int hold, input bit expect_pulse);
    int e0;
    e0       = edge_cnt + 1;
    btn_step = 1'b1;
    if (expect_pulse) push_strobe(e0 + 7);
    wait_edge(e0 + hold - 1);
    btn_step = 1'b0;
    wait_edge(edge_cnt + 12);
  endtask

  task automatic start_run(output int r);
    r      = edge_cnt + 1 + 6;
    sw_run = 1'b1;
    wait_edge(r - 1);
    check("running_before_accept", int'(running), 0);
    wait_edge(r);
    check("running_rise", int'(running), 1);
    check("halted_in_run", int'(halted), 0);
  endtask

  task automatic stop_run();
    int t;
    t      = edge_cnt + 1;
    sw_run = 1'b0;
    wait_edge(t + 5);
    check("running_before_release", int'(running), 1);
    wait_edge(t + 6);
    check("running_fall", int'(running), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int d;
    int l;
    int r2;
    int fin;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_running", int'(running), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_step_count", int'(step_count), 0);
    rst = 1'b0;
    wait_edge(edge_cnt + 5);

    // Clean press held 50 cycles: one pulse at cycle 7.
    press(50, 1'b1);
    check("count_after_clean", int'(step_count), CNT_EN ? 1 : 0);

    // Bouncy press 1,0,1,0 then high: one pulse 7 cycles after final rise.
    btn_step = 1'b1;
    @(negedge clk) btn_step = 1'b0;
    @(negedge clk) btn_step = 1'b1;
    @(negedge clk) btn_step = 1'b0;
    @(negedge clk) btn_step = 1'b1;
    fin = edge_cnt + 1;
    push_strobe(fin + 7);
    wait_edge(fin + 15);
    btn_step = 1'b0;
    wait_edge(edge_cnt + 12);
    check("count_after_bouncy", int'(step_count), CNT_EN ? 2 : 0);

    // Run mode: 11 strobes 10 apart, a press during run is ignored.
    start_run(r);
    for (int k = 0; k < 11; k++) push_strobe(r + 11 + 10 * k);
    wait_edge(r + 1);
    press(12, 1'b0);
    wait_edge(r + 111 + 1);
    stop_run();
    wait_edge(edge_cnt + 30);
    check("count_after_run", int'(step_count), CNT_EN ? 13 : 0);

    // Halt arriving exactly when the 4th strobe is due.
    start_run(r);
    for (int k = 0; k < 3; k++) push_strobe(r + 11 + 10 * k);
    d = r + 41;
    wait_edge(d - 1);
    halt = 1'b1;
    wait_edge(d);
    check("halt_halted", int'(halted), 1);
    check("halt_running", int'(running), 0);
    check("halt_cpu_en", int'(cpu_en), 0);
    wait_edge(d + 3);
    halt = 1'b0;
    wait_edge(d + 8);
    check("halted_while_run_held", int'(halted), 1);
    begin
      int t;
      t      = edge_cnt + 1;
      sw_run = 1'b0;
      wait_edge(t + 5);
      check("halted_before_release", int'(halted), 1);
      wait_edge(t + 6);
      check("halted_exit", int'(halted), 0);
      check("running_after_halt_exit", int'(running), 0);
    end
    wait_edge(edge_cnt + 5);
    press(12, 1'b1);
    check("count_after_halt", int'(step_count), CNT_EN ? 1 : 0);

    // Reset in the middle of run mode.
    start_run(r);
    for (int k = 0; k < 3; k++) push_strobe(r + 11 + 10 * k);
    l = r + 31;
    wait_edge(l + 2);
    rst = 1'b1;
    wait_edge(l + 3);
    rst   = 1'b0;
    m_cnt = 0;
    check("midrst_cpu_en", int'(cpu_en), 0);
    check("midrst_running", int'(running), 0);
    check("midrst_halted", int'(halted), 0);
    check("midrst_step_count", int'(step_count), 0);
    r2 = l + 3 + 7;
    wait_edge(r2 - 1);
    check("running_before_reaccept", int'(running), 0);
    wait_edge(r2);
    check("running_reaccepted", int'(running), 1);
    push_strobe(r2 + 11);
    push_strobe(r2 + 21);
    wait_edge(r2 + 22);
    stop_run();
    wait_edge(edge_cnt + 20);
    check("count_after_rerun", int'(step_count), CNT_EN ? 2 : 0);

    // Counter wrap: 17 presses on a 4-bit counter from zero.
    rst = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    m_cnt = 0;
    wait_edge(edge_cnt + 5);
    for (int k = 0; k < 17; k++) press(10, 1'b1);
    check("count_wrap", int'(step_count), CNT_EN ? 1 : 0);

    wait_edge(edge_cnt + 20);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution-rate controller for the single-cycle RISC-V core, sitting directly downstream of the board clock divider. It runs on the board clock, debounces the STEP push button and the RUN switch, and issues a one-cycle `cpu_en` strobe that the core uses as its clock enable. The core therefore advances either once per button press (step mode) or once every `RUN_DIV` cycles (run mode), and it stops on a halt request from the core.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized cycles required before an input level change is accepted; ≥2.
- `RUN_DIV`, 10: run-mode strobe period in `clk` cycles; ≥2.
- `CNT_W`, 16: width of `step_count`.
- `clk`  input  1  board clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `btn_step`  input  1  raw, asynchronous, bouncing STEP push button; active-high.
- `sw_run`  input  1  raw, asynchronous RUN slide switch; 1 = run mode.
- `halt`  input  1  synchronous halt request from the core (ecall/ebreak); level.
- `cpu_en`  output  1  registered single-cycle core advance strobe.
- `running`  output  1  registered; high while in RUN.
- `halted`  output  1  registered; high while in HALTED.
- `step_count`  output  CNT_W  registered count of issued `cpu_en` strobes.

## Operation
- Input conditioning: `btn_step` and `sw_run` each pass through a 2-FF synchronizer, then through an independent debouncer.
- Debouncer: the counter clears whenever the synchronized level equals the accepted level. Otherwise it increments each cycle. When `DEBOUNCE_CYCLES` consecutive differing cycles have been seen, the accepted level takes the new value and the counter clears.
- Step edge: the accepted button level rising 0→1 produces one step request. Holding the button produces no further requests. A release and a new accepted press are required for the next request.
- FSM states: IDLE, RUN, HALTED. Reset state is IDLE.
  - IDLE: a step request produces `cpu_en`=1 for exactly one cycle. Accepted run=1 → RUN with the divider counter cleared.
  - RUN: the divider counts 0..RUN_DIV-1 and wraps. `cpu_en`=1 in the cycle after the count equals RUN_DIV-1. Step requests are ignored. Accepted run=0 → IDLE, and no further strobes are issued.
  - HALTED: `cpu_en` is held at 0 and step requests are ignored. The FSM returns to IDLE only when `halt`=0 and accepted run=0.
  - Any state: `halt`=1 sampled → HALTED next cycle. This takes priority over step requests, run changes and a strobe due in that cycle (the strobe is suppressed).
- `step_count` increments by 1 on every cycle where `cpu_en`=1. It wraps modulo 2^CNT_W and is not cleared by mode changes.
- `rst` mid-operation clears everything on the next edge: the FSM, synchronizers, debouncers (accepted levels 0), the divider and the counter. If the button is held through reset, it produces a step once it is accepted after reset.

## Timing
- Reset values: `cpu_en`=0, `running`=0, `halted`=0, `step_count`=0.
- Step latency: `cpu_en` is high exactly in cycle DEBOUNCE_CYCLES+3, counting the first edge that samples `btn_step`=1 as cycle 0, provided the input stays stable. The pulse width is always 1 cycle.
- Run: the first strobe occurs RUN_DIV+1 cycles after `running` rises. After that, strobes are exactly RUN_DIV cycles apart. Each strobe is a 1-in-RUN_DIV duty, single-cycle pulse.
- Halt: the cycle after `halt` is sampled high, `cpu_en`=0 and `halted`=1.
- `running` and `halted` change on the same edge as the state register. They are never both 1.
- A bounce shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.

## Configuration
- `CPU_STEP_COUNT_EN` defined: the `step_count` counter is implemented as described above.
- `CPU_STEP_COUNT_EN` undefined: no counter flops are built, `step_count` is tied to 0, and all other behaviour is identical.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, IDLE: `btn_step` high at cycle 0 and held for 50 cycles → a single `cpu_en` pulse in cycle 7, and `step_count`=1.
- Bouncy press: `btn_step` toggles 1,0,1,0 on single cycles, then stays high → no pulse during the bounce, then exactly one pulse 7 cycles after the final rise.
- Run mode, RUN_DIV=10: `sw_run`=1 held → `running`=1, then `cpu_en` pulses spaced exactly 10 cycles apart. Over 100 cycles after the first pulse, 10 strobes are issued. Step presses during run produce no extra pulses.
- Halt in RUN: assert `halt` in the same cycle a strobe is due → no strobe, and `halted`=1 next cycle. With `halt`=0 and `sw_run`=0 → IDLE. A subsequent press is stepped again.
- Reset mid-run: assert `rst` for 1 cycle with `step_count`=37 → all outputs are 0 next cycle. The FSM is in IDLE until `sw_run` is re-accepted.
- Wrap, CNT_W=4: 17 step presses → `step_count`=1. With `CPU_STEP_COUNT_EN` undefined, `step_count` stays 0 throughout.
